// File: rtl/pixel_line_feeder.sv
// Streams an 8-bit frame from synchronous memory to the image core.
// Primes a few lines, then sends one line per request edge and pads with zero lines.
module pixel_line_feeder #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              pixel_request,
  output logic              pixel_valid,
  output logic [7:0]        pixel_input,
  output logic              busy,
  output logic              done,
  output logic              req_overrun
);

  localparam int CNT_W = $clog2(PRIME_LINES * IMG_WIDTH + 1);
  localparam int LN_W  = $clog2(IMG_HEIGHT + 1);
  localparam int PD_W  = $clog2(PAD_LINES + 2);

  localparam logic [CNT_W-1:0] PRIME_LAST =
    CNT_W'(PRIME_LINES * IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);
  localparam logic [LN_W-1:0]  N_LINES = LN_W'(IMG_HEIGHT);
  localparam logic [LN_W-1:0]  N_PRIME = LN_W'(PRIME_LINES);
  localparam logic [PD_W-1:0]  N_PADS = PD_W'(PAD_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_LINE,
    S_PAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic             req_q;
  logic             pending;
  logic             pad_stb;
  logic             s1;
  logic             z1;
  logic [CNT_W-1:0] cnt;
  logic [LN_W-1:0]  lines_sent;
  logic [PD_W-1:0]  pads;

  logic req_edge;
  logic active;
  logic take;

  assign req_edge = pixel_request & ~req_q;
  assign active = (state != S_IDLE) && (state != S_DONE);
  assign take = (state == S_WAIT) && (pads != N_PADS)
             && (pending || req_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      pending     <= 1'b0;
      pad_stb     <= 1'b0;
      s1          <= 1'b0;
      z1          <= 1'b0;
      cnt         <= '0;
      lines_sent  <= '0;
      pads        <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      pixel_valid <= 1'b0;
      pixel_input <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_overrun <= 1'b0;
    end else begin
      req_q       <= pixel_request;
      s1          <= mem_rd_en | pad_stb;
      z1          <= pad_stb;
      pixel_valid <= s1;
      pixel_input <= (s1 && !z1) ? mem_rdata : 8'd0;

      // A consumed request with a fresh edge keeps the edge queued.
      if (take) begin
        pending <= pending & req_edge;
      end else if (active && req_edge) begin
        if (pending) req_overrun <= 1'b1;
        else pending <= 1'b1;
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_PRIME;
            busy        <= 1'b1;
            done        <= 1'b0;
            mem_rd_en   <= 1'b1;
            mem_addr    <= '0;
            cnt         <= '0;
            lines_sent  <= '0;
            pads        <= '0;
            pending     <= 1'b0;
            req_overrun <= 1'b0;
          end
        end
        S_PRIME: begin
          mem_addr <= mem_addr + 1'b1;
          if (cnt == PRIME_LAST) begin
            mem_rd_en  <= 1'b0;
            cnt        <= '0;
            lines_sent <= N_PRIME;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= '0;
          if (pads == N_PADS) begin
            state <= S_DRAIN;
          end else if (pending || req_edge) begin
            if (lines_sent < N_LINES) begin
              state     <= S_LINE;
              mem_rd_en <= 1'b1;
            end else begin
              state   <= S_PAD;
              pad_stb <= 1'b1;
            end
          end
        end
        S_LINE: begin
          mem_addr <= mem_addr + 1'b1;
          if (cnt == LINE_LAST) begin
            mem_rd_en  <= 1'b0;
            cnt        <= '0;
            lines_sent <= lines_sent + 1'b1;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAD: begin
          if (cnt == LINE_LAST) begin
            pad_stb <= 1'b0;
            cnt     <= '0;
            pads    <= pads + 1'b1;
            state   <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_line_feeder.sv
// Randomized bench for pixel_line_feeder with a queue-based pixel stream model.
// Expected stream: frame memory in raster order followed by zero pad lines.
module tb_pixel_line_feeder;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int P  = 4;
  localparam int PD = 2;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          pixel_request;
  logic          pixel_valid;
  logic [7:0]    pixel_input;
  logic          busy;
  logic          done;
  logic          req_overrun;

  pixel_line_feeder #(
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .PRIME_LINES(P),
    .PAD_LINES(PD),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .pixel_request(pixel_request),
    .pixel_valid(pixel_valid),
    .pixel_input(pixel_input),
    .busy(busy),
    .done(done),
    .req_overrun(req_overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [W*H];

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int lines_exp;
  int pix_cnt;
  int rd_idx;
  int run;
  int nrun;
  int cyc;
  int first_rd;
  int first_pv;
  int last_pix;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_step();
    cyc++;
    if (!rst) begin
      run = 0;
    end else begin
      if (start) begin
        pix_cnt = 0;
        rd_idx = 0;
        run = 0;
        nrun = 0;
        first_rd = -1;
        first_pv = -1;
      end
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("mem_addr", int'(mem_addr), rd_idx);
        rd_idx++;
      end
      if (pixel_valid) begin
        if (first_pv < 0) first_pv = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_pixel", int'(pixel_input), -1);
        end else begin
          chk("pixel", int'(pixel_input), exp_q.pop_front());
        end
        last_pix = int'(pixel_input);
        pix_cnt++;
        run++;
      end else if (run != 0) begin
        chk("burst_len", run, (nrun == 0) ? P * W : W);
        nrun++;
        run = 0;
      end
      chk("busy_done_excl", int'(busy & done), 0);
    end
  endtask

  task automatic new_frame(input bit identity);
    for (int i = 0; i < W * H; i++)
      mem[i] = identity ? 8'(i) : 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < W * H; i++) exp_q.push_back(int'(mem[i]));
    for (int i = 0; i < PD * W; i++) exp_q.push_back(0);
    lines_exp = P;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse(input int width);
    @(posedge clk); #1 pixel_request = 1'b1;
    repeat (width) @(posedge clk);
    #1 pixel_request = 1'b0;
  endtask

  task automatic step_req(input int gap, input int width);
    repeat (gap) @(posedge clk);
    pulse(width);
    repeat (16) @(posedge clk);
    #1;
    if (lines_exp < H + PD) lines_exp++;
    chk("lines_after_req", pix_cnt, lines_exp * W);
  endtask

  task automatic frame_end();
    chk("done_at_end", int'(done), 1);
    chk("busy_at_end", int'(busy), 0);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_valid"}, int'(pixel_valid), 0);
    chk({tag, "_pixel"}, int'(pixel_input), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_overrun"}, int'(req_overrun), 0);
  endtask

  task automatic main();
    bit hit;
    rst = 1'b0;
    start = 1'b0;
    pixel_request = 1'b0;
    new_frame(1'b1);
    #3;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Frame A: prime only, then the full frame
    new_frame(1'b1);
    do_start();
    repeat (50) @(posedge clk);
    #1;
    chk("prime_count", pix_cnt, 32);
    chk("prime_last", last_pix, 31);
    chk("prime_busy", int'(busy), 1);
    chk("prime_idle_valid", int'(pixel_valid), 0);
    chk("prime_latency", first_pv - first_rd, 2);
    chk("prime_not_done", int'(done), 0);
    for (int i = 0; i < H - P + PD; i++) step_req(3, 1);
    frame_end();
    chk("frame_total", pix_cnt, 80);
    step_req(3, 1);
    chk("seventh_req_ignored", pix_cnt, 80);

    // Frame B: early request during prime, then overrun
    new_frame(1'b0);
    do_start();
    repeat (10) @(posedge clk);
    pulse(1);
    repeat (60) @(posedge clk);
    #1;
    lines_exp = 5;
    chk("early_req_count", pix_cnt, 40);
    chk("early_no_overrun", int'(req_overrun), 0);
    pulse(1);
    repeat (2) @(posedge clk);
    pulse(1);
    pulse(1);
    repeat (30) @(posedge clk);
    #1;
    lines_exp = 7;
    chk("overrun_count", pix_cnt, 56);
    chk("overrun_set", int'(req_overrun), 1);
    for (int i = 0; i < 3; i++) step_req(3, 1);
    chk("overrun_sticky", int'(req_overrun), 1);
    frame_end();

    // Frame C: start clears overrun, reset mid-line
    new_frame(1'b1);
    do_start();
    #1;
    chk("start_clears_overrun", int'(req_overrun), 0);
    repeat (50) @(posedge clk);
    step_req(3, 1);
    pulse(1);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #1;
      if (pix_cnt >= 44) hit = 1'b1;
    end
    chk("reset_point", pix_cnt, 44);
    rst = 1'b0;
    #1;
    chk_zero_outputs("midline_reset");
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    new_frame(1'b1);
    do_start();
    repeat (50) @(posedge clk);
    #1;
    chk("restart_count", pix_cnt, 32);
    chk("restart_last", last_pix, 31);
    chk("restart_latency", first_pv - first_rd, 2);
    // request held high across the burst end
    step_req(2, 20);
    for (int i = 0; i < H - P + PD - 1; i++) step_req(3, 1);
    frame_end();

    // Randomized frames
    for (int f = 0; f < 3; f++) begin
      new_frame(1'b0);
      do_start();
      repeat (45) @(posedge clk);
      #1;
      chk("rand_prime", pix_cnt, P * W);
      for (int i = 0; i < H - P + PD; i++)
        step_req(int'($urandom_range(1, 10)), int'($urandom_range(1, 20)));
      frame_end();
      chk("rand_no_overrun", int'(req_overrun), 0);
    end
  endtask

  initial begin
    cyc = 0;
    pix_cnt = 0;
    rd_idx = 0;
    run = 0;
    nrun = 0;
    first_rd = -1;
    first_pv = -1;
    last_pix = -1;
    fork
      begin
        forever begin
          @(negedge clk);
          cmp_step();
        end
      end
      begin
        main();
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_line_feeder.md
Name: pixel_line_feeder

Overview:
- Streaming source that drives the pixel input side of the image processing core, replacing the behavioural file-driven stimulus.
- Reads an 8-bit grayscale frame from a synchronous frame memory and primes PRIME_LINES lines back-to-back.
- After priming, sends one further line per rising edge of the core's pixel_request interrupt.
- Finishes with PAD_LINES zero-valued lines so the core can flush its line buffers.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame; must be >= PRIME_LINES
PRIME_LINES, 4, lines sent without waiting for pixel_request
PAD_LINES, 2, zero lines appended after the frame, each gated by pixel_request
ADDR_W, 18, frame memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when in IDLE; ignored elsewhere
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W  frame memory read address, linear raster order starting at 0
mem_rdata  in  8  read data, valid exactly one cycle after mem_rd_en
pixel_request  in  1  core interrupt requesting next line; level signal, edge-detected internally
pixel_valid  out  1  registered pixel strobe to the core
pixel_input  out  8  registered pixel value to the core
busy  out  1  high from the cycle after accepted start until DONE
done  out  1  high in DONE state until the next start
req_overrun  out  1  sticky; set when a request edge arrives while one is already pending; cleared by start

Behaviour:
- Reset (async, rst=0): state IDLE; mem_rd_en=0, mem_addr=0, pixel_valid=0, pixel_input=0, busy=0, done=0, req_overrun=0; pending flag, counters and edge-detect register cleared. Reset mid-line aborts the line immediately with no further valid pixels.
- Read pipeline: mem_rd_en in cycle t -> mem_rdata in t+1 -> pixel_valid/pixel_input registered in t+2. Fixed latency 2 from read strobe to pixel.
- Padding lines: no memory reads; the same 2-cycle internal strobe pipeline drives pixel_input=0.
- Line burst: exactly IMG_WIDTH consecutive cycles of pixel_valid=1. Between bursts, pixel_valid=0 for at least 1 cycle.
- mem_addr increments by 1 per read and never wraps within a frame. The final image read is at address IMG_WIDTH*IMG_HEIGHT-1.
- Request detection: edge = pixel_request & ~pixel_request_q. Any edge seen outside IDLE/DONE sets pending.
  - If pending is already set when an edge arrives, the edge is dropped and req_overrun is set.
  - Edges seen in IDLE or DONE are ignored.
- States:
  - IDLE: on start -> PRIME; lines_sent=0, addr=0, pending=0, req_overrun=0.
  - PRIME: issues PRIME_LINES*IMG_WIDTH contiguous reads, then -> WAIT_REQ. Edges during PRIME set pending.
  - WAIT_REQ: if pending or edge this cycle -> clear pending; go to LINE if lines_sent < IMG_HEIGHT, otherwise PAD. If padded lines = PAD_LINES -> DRAIN.
  - LINE: IMG_WIDTH reads; lines_sent += 1 -> WAIT_REQ.
  - PAD: IMG_WIDTH zero strobes; pads += 1 -> WAIT_REQ.
  - DRAIN: waits until the pipeline is empty (2 cycles) -> DONE.
  - DONE: done=1, busy=0; start -> PRIME with the same init as IDLE.
- Simultaneous edge and burst end in the same cycle: the edge is registered as pending and is not lost.
- busy deasserts the same cycle done asserts.
- Total pixels per frame: (IMG_HEIGHT+PAD_LINES)*IMG_WIDTH.
- Request edges consumed per frame: (IMG_HEIGHT-PRIME_LINES)+PAD_LINES.

Test Plan:
- Prime: IMG_WIDTH=8, IMG_HEIGHT=8, memory holds addr[7:0]; start pulse, no requests.
  -> 32 contiguous pixel_valid with values 0..31, first valid 2 cycles after first mem_rd_en.
  -> then idle in WAIT_REQ: pixel_valid=0, busy=1.
- Full frame: same config, pixel_request pulsed 3 cycles after each burst ends.
  -> 8 image lines (0..63) then 2 lines of 8 zeros; done=1 after 6 request pulses; the 7th pulse causes no output.
- Early request: pixel_request rises during PRIME.
  -> pending set; line 4 (values 32..39) starts within 2 cycles of PRIME end with no extra pulse.
- Overrun: two request edges during one LINE burst.
  -> req_overrun=1 and stays high.
  -> exactly one extra line sent; the next start clears req_overrun.
- Reset mid-line: rst=0 on the 4th pixel of line 5.
  -> all outputs 0 asynchronously, state IDLE.
  -> a subsequent start restarts at addr 0 and emits 0..31.
- Edge/boundary: pixel_request held high across a burst end (no new edge) -> no new line.
- Default params smoke: 512x512 -> 263168 valid pixels, last image pixel from addr 262143.
